game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, default 3, sets the number of playable levels (1..8).
REQ-002 Parameter NUM_LIVES, default 3, sets the lives granted per game (1..7); NUM_LIVES+NUM_LEVELS SHALL be <= 10.
REQ-003 Parameter RESPAWN_CYCLES, default 16, sets the length of the level reset pulse in cycles (>= 2).
REQ-004 vga_clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 left_switch, right_switch, jump_button  in  1 each  player controls.
REQ-007 start_button  in  1  active-low start/restart button.
REQ-008 level_win, level_lose  in  NUM_LEVELS each  per-level win/lose flags; bit i comes from level i.
REQ-009 start_rgb, win_rgb, over_rgb  in  12 each  screen colours, packed {r,g,b} at 4 bits each.
REQ-010 level_rgb  in  12*NUM_LEVELS  per-level colours; level i occupies bits [12i+11:12i].
REQ-011 level_reset_n  out  NUM_LEVELS  active-low reset to each level.
REQ-012 level_left, level_right, level_jump  out  NUM_LEVELS each  controls routed to the levels.
REQ-013 vga_red, vga_green, vga_blue  out  4 each  selected colour, registered.
REQ-014 current_level  out  3  index of the active level.
REQ-015 lives  out  3  remaining lives.
REQ-016 leds  out  10  status display.

Function
REQ-017 The block SHALL be a state machine with states START, PLAY, RESPAWN, WIN and GAME_OVER.
REQ-018 A start press is a 1->0 transition of start_button, detected against a registered copy of the previous sample; a held-low button SHALL generate only one press.
REQ-019 START: on a start press, set current_level=0 and lives=NUM_LIVES, and enter RESPAWN.
REQ-020 RESPAWN: drive level_reset_n[current_level]=0 for exactly RESPAWN_CYCLES cycles using a down-counter, then enter PLAY.
REQ-021 PLAY, active level's level_win=1: if current_level==NUM_LEVELS-1, enter WIN; otherwise increment current_level and enter RESPAWN.
REQ-022 PLAY, active level's level_lose=1 (win not asserted): decrement lives; if lives was 1, enter GAME_OVER; otherwise re-enter RESPAWN on the same level.
REQ-023 If win and lose are asserted in the same cycle, win SHALL take priority and lives SHALL be unchanged.
REQ-024 level_win and level_lose bits of inactive levels SHALL be ignored in every state.
REQ-025 WIN and GAME_OVER: on a start press, enter START; current_level and lives are held until then.
REQ-026 Control routing: in PLAY, level_left/right/jump[current_level] follow the inputs combinationally; all other bits, and all bits in every other state, are 0.
REQ-027 level_reset_n SHALL be 1 for every level except the active level during RESPAWN, and except all levels during reset.
REQ-028 Colour select, registered with 1-cycle latency:
  - START -> start_rgb
  - PLAY or RESPAWN -> level_rgb of current_level
  - WIN -> win_rgb
  - GAME_OVER -> over_rgb
REQ-029 leds[NUM_LIVES-1:0] SHALL show lives as a thermometer code.
REQ-030 leds[NUM_LIVES+:NUM_LEVELS] SHALL be one-hot on current_level in PLAY or RESPAWN, and 0 otherwise.
REQ-031 All leds bits not assigned by REQ-029 and REQ-030 SHALL be 0.

Reset
REQ-032 While reset=0 at a clock edge, the block SHALL apply these values:
  - state=START, current_level=0, lives=NUM_LIVES, RESPAWN counter=0
  - vga_red, vga_green, vga_blue = 0
  - level_reset_n = all 0
  - start-button history register = 1
REQ-033 A reset asserted mid-RESPAWN or mid-PLAY SHALL abandon the game and return to START on the next edge.

Structure
REQ-034 The state enum, the 12-bit rgb typedef and the LED field offsets SHALL be defined in the shared package game_pkg.
REQ-035 The press detector SHALL be the sub-module button_edge (active-low input, one-cycle pulse output).

Verification
REQ-036 Start handshake: NUM_LEVELS=3, NUM_LIVES=3, start_button held low for 100 cycles -> exactly one RESPAWN; level_reset_n=3'b110 for 16 cycles; then PLAY with current_level=0.
REQ-037 Level progression: level_win[0] pulse, then level_win[1] pulse, then level_win[2] pulse -> current_level goes 1, then 2, then state WIN; colour output equals win_rgb one cycle later.
REQ-038 Lives: three level_lose[0] pulses, each in PLAY -> lives goes 2, 1, then GAME_OVER; leds[2:0] goes 011, 001, 000.
REQ-039 Priority and isolation: level_win[0]=level_lose[0]=1 together -> level advances and lives stay 3; level_lose[2]=1 while on level 0 -> no effect.
REQ-040 Routing: in PLAY on level 1 with left_switch=1 -> level_left=3'b010; during RESPAWN -> level_left=3'b000.
REQ-041 Reset mid-RESPAWN: reset=0 at cycle 5 of RESPAWN -> START next edge with all outputs at their REQ-032 values; a start press from GAME_OVER returns to START with lives=3.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, colour type and LED layout for game_sequencer.
package game_pkg;
    typedef enum logic [2:0] {ST_START, ST_PLAY, ST_RESPAWN, ST_WIN, ST_OVER} state_t;
    typedef logic [11:0] rgb_t;
    localparam int LED_W         = 10;
    localparam int LED_LIVES_OFF = 0;
    function automatic int led_level_off(input int num_lives);
        return LED_LIVES_OFF + num_lives;
    endfunction
endpackage

// File: rtl/game_sequencer_button_edge.sv
// button_edge: one-cycle pulse on the 1->0 edge of an active-low button.
module button_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press
);
    logic r_prev;
    always_ff @(posedge i_clk) r_prev <= !i_rst_n ? 1'b1 : i_btn_n;
    assign o_press = r_prev & ~i_btn_n;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow (start, respawn, play, win, game over),
// routing player controls and colour to the active level.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS     = 3,
    parameter int NUM_LIVES      = 3,
    parameter int RESPAWN_CYCLES = 16
) (
    input  logic                    vga_clock,
    input  logic                    reset,
    input  logic                    left_switch,
    input  logic                    right_switch,
    input  logic                    jump_button,
    input  logic                    start_button,
    input  logic [NUM_LEVELS-1:0]   level_win,
    input  logic [NUM_LEVELS-1:0]   level_lose,
    input  logic [11:0]             start_rgb,
    input  logic [11:0]             win_rgb,
    input  logic [11:0]             over_rgb,
    input  logic [12*NUM_LEVELS-1:0] level_rgb,
    output logic [NUM_LEVELS-1:0]   level_reset_n,
    output logic [NUM_LEVELS-1:0]   level_left,
    output logic [NUM_LEVELS-1:0]   level_right,
    output logic [NUM_LEVELS-1:0]   level_jump,
    output logic [3:0]              vga_red,
    output logic [3:0]              vga_green,
    output logic [3:0]              vga_blue,
    output logic [2:0]              current_level,
    output logic [2:0]              lives,
    output logic [LED_W-1:0]        leds
);
    localparam int CW      = $clog2(RESPAWN_CYCLES + 1);
    localparam int LVL_OFF = led_level_off(NUM_LIVES);

    state_t                r_state, w_state;
    logic [2:0]            r_level, w_level, r_lives, w_lives;
    logic [CW-1:0]         r_cnt, w_cnt;
    rgb_t                  r_rgb, w_rgb;
    logic [NUM_LEVELS-1:0] r_rst_n, w_rst_n, w_oh, w_next_oh;
    logic [7:0]            w_win_all, w_lose_all;
    logic [LED_W-1:0]      w_therm;
    logic                  w_press, w_win, w_lose, w_show_lvl;
    rgb_t                  w_lvl_rgb [8];

    button_edge u_start (
        .i_clk   (vga_clock),
        .i_rst_n (reset),
        .i_btn_n (start_button),
        .o_press (w_press)
    );

    for (genvar i = 0; i < 8; i++) begin : g_rgb
        if (i < NUM_LEVELS) begin : g_lvl
            assign w_lvl_rgb[i] = level_rgb[12*i +: 12];
        end else begin : g_pad
            assign w_lvl_rgb[i] = '0;
        end
    end

    // Only the active level's flags are ever looked at.
    assign w_win_all  = 8'(level_win);
    assign w_lose_all = 8'(level_lose);
    assign w_win      = w_win_all[r_level];
    assign w_lose     = w_lose_all[r_level];
    assign w_oh       = NUM_LEVELS'(1) << r_level;
    assign w_next_oh  = NUM_LEVELS'(1) << w_level;

    always_comb begin
        w_state = r_state;
        w_level = r_level;
        w_lives = r_lives;
        w_cnt   = r_cnt;
        case (r_state)
            ST_START: if (w_press) begin
                w_state = ST_RESPAWN;
                w_level = '0;
                w_lives = 3'(NUM_LIVES);
                w_cnt   = CW'(RESPAWN_CYCLES);
            end
            ST_RESPAWN: begin
                w_cnt   = r_cnt - 1'b1;
                w_state = r_cnt == CW'(1) ? ST_PLAY : ST_RESPAWN;
            end
            ST_PLAY: if (w_win) begin
                if (r_level == 3'(NUM_LEVELS - 1)) w_state = ST_WIN;
                else begin
                    w_level = r_level + 3'd1;
                    w_cnt   = CW'(RESPAWN_CYCLES);
                    w_state = ST_RESPAWN;
                end
            end else if (w_lose) begin
                w_lives = r_lives - 3'd1;
                w_cnt   = CW'(RESPAWN_CYCLES);
                w_state = r_lives == 3'd1 ? ST_OVER : ST_RESPAWN;
            end
            default: if (w_press) begin
                w_state = ST_START;
                w_level = '0;
                w_lives = 3'(NUM_LIVES);
            end
        endcase
    end

    // Level reset is registered from the next state so it lines up with r_state.
    assign w_rst_n = w_state == ST_RESPAWN ? ~w_next_oh : '1;
    assign w_rgb   = r_state == ST_START ? start_rgb :
                     r_state == ST_WIN   ? win_rgb   :
                     r_state == ST_OVER  ? over_rgb  : w_lvl_rgb[r_level];

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            r_state <= ST_START;
            r_level <= '0;
            r_lives <= 3'(NUM_LIVES);
            r_cnt   <= '0;
            r_rgb   <= '0;
            r_rst_n <= '0;
        end else begin
            r_state <= w_state;
            r_level <= w_level;
            r_lives <= w_lives;
            r_cnt   <= w_cnt;
            r_rgb   <= w_rgb;
            r_rst_n <= w_rst_n;
        end
    end

    assign w_show_lvl    = r_state == ST_PLAY || r_state == ST_RESPAWN;
    assign w_therm       = (LED_W'(1) << r_lives) - LED_W'(1);
    assign leds          = w_therm | (w_show_lvl ? LED_W'(w_oh) << LVL_OFF : '0);
    assign level_left    = r_state == ST_PLAY && left_switch  ? w_oh : '0;
    assign level_right   = r_state == ST_PLAY && right_switch ? w_oh : '0;
    assign level_jump    = r_state == ST_PLAY && jump_button  ? w_oh : '0;
    assign level_reset_n = r_rst_n;
    assign current_level = r_level;
    assign lives         = r_lives;
    assign {vga_red, vga_green, vga_blue} = r_rgb;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios plus random play checked every cycle
// against a behavioural model of the game rules.
module tb_game_sequencer;
    localparam int NLV = 3, NLF = 3, RC = 16;
    localparam int M_START = 0, M_PLAY = 1, M_RESP = 2, M_WIN = 3, M_OVER = 4;

    logic clk = 0, reset = 0, left = 0, right = 0, jump = 0, start = 1;
    logic [2:0] win = 0, lose = 0;
    logic [11:0] srgb = 12'hA01, wrgb = 12'h0B2, orgb = 12'hC03;
    logic [35:0] lrgb = 36'h3D3_2E2_1F1;
    logic [2:0] lrn, ll, lr, lj, cur, lv;
    logic [3:0] vr, vg, vb;
    logic [9:0] leds;

    int checks = 0, errors = 0;
    int m_mode = M_START, m_lvl = 0, m_lives = NLF, m_rem = 0, m_rgb = 0;
    bit m_prev = 1, m_inrst = 1;

    game_sequencer #(.NUM_LEVELS(NLV), .NUM_LIVES(NLF), .RESPAWN_CYCLES(RC)) dut (
        .vga_clock(clk), .reset(reset), .left_switch(left), .right_switch(right),
        .jump_button(jump), .start_button(start), .level_win(win), .level_lose(lose),
        .start_rgb(srgb), .win_rgb(wrgb), .over_rgb(orgb), .level_rgb(lrgb),
        .level_reset_n(lrn), .level_left(ll), .level_right(lr), .level_jump(lj),
        .vga_red(vr), .vga_green(vg), .vga_blue(vb), .current_level(cur),
        .lives(lv), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int colour(input int mode, input int lvl);
        if (mode == M_START) return int'(srgb);
        if (mode == M_WIN) return int'(wrgb);
        if (mode == M_OVER) return int'(orgb);
        return int'(lrgb[12*lvl +: 12]);
    endfunction

    task automatic step;
        bit press;
        if (!reset) begin
            m_mode = M_START; m_lvl = 0; m_lives = NLF; m_rem = 0;
            m_prev = 1; m_rgb = 0; m_inrst = 1;
        end else begin
            m_inrst = 0;
            m_rgb = colour(m_mode, m_lvl);
            press = m_prev && !start;
            m_prev = start;
            if (m_mode == M_START && press) begin
                m_lvl = 0; m_lives = NLF; m_rem = RC; m_mode = M_RESP;
            end else if (m_mode == M_RESP) begin
                m_rem--;
                if (m_rem == 0) m_mode = M_PLAY;
            end else if (m_mode == M_PLAY && win[m_lvl]) begin
                if (m_lvl == NLV - 1) m_mode = M_WIN;
                else begin m_lvl++; m_rem = RC; m_mode = M_RESP; end
            end else if (m_mode == M_PLAY && lose[m_lvl]) begin
                m_lives--;
                if (m_lives == 0) m_mode = M_OVER;
                else begin m_rem = RC; m_mode = M_RESP; end
            end else if ((m_mode == M_WIN || m_mode == M_OVER) && press) begin
                m_mode = M_START; m_lvl = 0; m_lives = NLF;
            end
        end
    endtask

    task automatic compare;
        int oh, route;
        oh = 1 << m_lvl;
        route = m_mode == M_PLAY ? oh : 0;
        check("level_reset_n", 32'(lrn), m_inrst ? 0 : (m_mode == M_RESP ? 7 & ~oh : 7));
        check("current_level", 32'(cur), m_lvl);
        check("lives", 32'(lv), m_lives);
        check("rgb", 32'({vr, vg, vb}), m_rgb);
        check("leds", 32'(leds), ((1 << m_lives) - 1) |
              ((m_mode == M_PLAY || m_mode == M_RESP) ? oh << NLF : 0));
        check("level_left", 32'(ll), left ? route : 0);
        check("level_right", 32'(lr), right ? route : 0);
        check("level_jump", 32'(lj), jump ? route : 0);
    endtask

    task automatic tick;
        @(posedge clk);
        step();
        #1;
        compare();
    endtask

    task automatic press_start;
        start = 0; tick(); start = 1; tick();
    endtask

    task automatic wait_mode(input int target, input int budget);
        int n = 0;
        while (m_mode != target && n < budget) begin tick(); n++; end
        check("wait_timeout", m_mode, target);
    endtask

    initial begin
        int rn;
        repeat (3) tick();
        reset = 1; tick();
        // held-low start gives a single respawn
        start = 0; rn = 0;
        repeat (100) begin tick(); if (lrn === 3'b110) rn++; end
        start = 1;
        check("respawn_len", rn, RC);
        check("play_level0", 32'(cur), 0);
        // progression through all levels
        for (int i = 0; i < NLV; i++) begin
            wait_mode(M_PLAY, 40);
            win = 3'(1 << i); tick(); win = 0;
            check("progress_level", 32'(cur), i == NLV - 1 ? NLV - 1 : i + 1);
        end
        tick();
        check("win_colour", 32'({vr, vg, vb}), 32'(wrgb));
        press_start();
        // lose all lives on level 0
        press_start();
        for (int i = 0; i < NLF; i++) begin
            wait_mode(M_PLAY, 40);
            lose = 3'b001; tick(); lose = 0;
            check("leds_lives", 32'(leds[2:0]), i == 0 ? 3 : i == 1 ? 1 : 0);
        end
        press_start();
        check("restart_lives", 32'(lv), NLF);
        // inactive lose ignored, then win beats lose
        press_start();
        wait_mode(M_PLAY, 40);
        lose = 3'b100; tick(); lose = 0;
        check("isolate_lives", 32'(lv), NLF);
        check("isolate_rst", 32'(lrn), 7);
        win = 3'b001; lose = 3'b001; tick(); win = 0; lose = 0;
        check("prio_level", 32'(cur), 1);
        check("prio_lives", 32'(lv), NLF);
        // routing on level 1 then in respawn
        wait_mode(M_PLAY, 40);
        left = 1; tick();
        check("route_play", 32'(ll), 3'b010);
        win = 3'b010; tick(); win = 0;
        check("route_respawn", 32'(ll), 0);
        left = 0;
        // reset in the middle of respawn
        repeat (4) tick();
        reset = 0; tick();
        check("rst_level", 32'(cur), 0);
        check("rst_lives", 32'(lv), NLF);
        check("rst_lrn", 32'(lrn), 0);
        check("rst_rgb", 32'({vr, vg, vb}), 0);
        check("rst_leds", 32'(leds), 10'h007);
        reset = 1;
        // random play
        repeat (4000) begin
            reset = $urandom_range(0, 399) != 0;
            if ($urandom_range(0, 7) == 0) start = ~start;
            win   = $urandom_range(0, 24) == 0 ? 3'($urandom) : 3'b000;
            lose  = $urandom_range(0, 19) == 0 ? 3'($urandom) : 3'b000;
            left  = 1'($urandom); right = 1'($urandom); jump = 1'($urandom);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
